// File: rtl/bus_6502_regfile_if.sv
// 6502 expansion-bus signal bundle between the CPU side (master) and the
// register file (slave).
interface bus_6502_regfile_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              clk_ext1;
   logic              cs;
   logic [ADDR_W-1:0] rs;
   logic              wren;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              data_oe;
   logic              irq_n;
   logic              wr_strobe;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        led;

   modport master (
      output clk_ext1, cs, rs, wren, data_in,
      input  data_out, data_oe, irq_n, wr_strobe, wr_addr, led
   );

   modport slave (
      input  clk_ext1, cs, rs, wren, data_in,
      output data_out, data_oe, irq_n, wr_strobe, wr_addr, led
   );
endinterface

// File: rtl/bus_6502_regfile.sv
// 6502 bus slave register file: oversampled phi2 access FSM, read-clear
// status/IRQ register and an LED mirror of one register.
module bus_6502_regfile #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int LED_REG     = 0
) (
   input  logic clk,
   input  logic rst_n,
   bus_6502_regfile_if.slave bus
);
   localparam int NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_REGS-1);

   typedef enum logic {IDLE, ACCESS} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0]             phi2_sync, cs_sync, wren_sync;
   logic [SYNC_STAGES-1:0][ADDR_W-1:0] rs_sync;
   logic [SYNC_STAGES-1:0][DATA_W-1:0] din_sync;
   logic                               phi2_d;

   // Bus inputs idle high (cs/wren inactive) so reset never fakes an access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phi2_sync <= '0;
         cs_sync   <= '1;
         wren_sync <= '1;
         rs_sync   <= '0;
         din_sync  <= '0;
         phi2_d    <= 1'b0;
      end else begin
         phi2_sync <= {phi2_sync[SYNC_STAGES-2:0], bus.clk_ext1};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0],   bus.cs};
         wren_sync <= {wren_sync[SYNC_STAGES-2:0], bus.wren};
         rs_sync   <= {rs_sync[SYNC_STAGES-2:0],   bus.rs};
         din_sync  <= {din_sync[SYNC_STAGES-2:0],  bus.data_in};
         phi2_d    <= phi2_sync[SYNC_STAGES-1];
      end
   end

   logic              phi2_s, cs_s, wren_s, rise, fall;
   logic [ADDR_W-1:0] rs_s;
   logic [DATA_W-1:0] din_s;
   assign phi2_s = phi2_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign wren_s = wren_sync[SYNC_STAGES-1];
   assign rs_s   = rs_sync[SYNC_STAGES-1];
   assign din_s  = din_sync[SYNC_STAGES-1];
   assign rise   = phi2_s & ~phi2_d;
   assign fall   = ~phi2_s & phi2_d;

   logic [ADDR_W-1:0] addr;
   logic              wr_n;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-2:0] count;
   logic              new_data;
   logic [DATA_W-1:0] status, rd_val;

   assign status = {count, new_data};
   assign rd_val = (addr == STAT_ADDR) ? status : regs[addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   logic start, commit, clr_status, rd_active;

   always_comb begin
      state_nxt  = state;
      start      = 1'b0;
      commit     = 1'b0;
      clr_status = 1'b0;
      rd_active  = 1'b0;
      case (state)
         IDLE: begin
            if (rise && !cs_s) begin
               start     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            // A fresh rise without a fall discards the pending access
            if (rise) begin
               start     = !cs_s;
               state_nxt = cs_s ? IDLE : ACCESS;
            end else if (fall) begin
               state_nxt  = IDLE;
               commit     = !cs_s && !wr_n && (addr != STAT_ADDR);
               clr_status = !cs_s && wr_n && (addr == STAT_ADDR);
            end else begin
               rd_active = wr_n;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr          <= '0;
         wr_n          <= 1'b1;
         count         <= '0;
         new_data      <= 1'b0;
         bus.data_out  <= '0;
         bus.data_oe   <= 1'b0;
         bus.irq_n     <= 1'b1;
         bus.wr_strobe <= 1'b0;
         bus.wr_addr   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (start) begin
            addr <= rs_s;
            wr_n <= wren_s;
         end
         bus.data_oe   <= rd_active;
         bus.wr_strobe <= commit;
         bus.irq_n     <= ~new_data;
         if (rd_active) bus.data_out <= rd_val;
         if (commit) begin
            regs[addr]  <= din_s;
            bus.wr_addr <= addr;
            count       <= count + 1'b1;
            new_data    <= 1'b1;
         end else if (clr_status) begin
            new_data <= 1'b0;
         end
      end
   end

   generate
      if (LED_REG == NUM_REGS-1) begin : g_led_status
         assign bus.led = status[7:0];
      end else begin : g_led_reg
         assign bus.led = regs[LED_REG][7:0];
      end
   endgenerate
endmodule

// File: tb/tb_bus_6502_regfile.sv
// Randomised scoreboard bench for bus_6502_regfile: a memory-array model
// predicts write addresses and read data; a monitor checks DUT outputs.
module tb_bus_6502_regfile;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bus_6502_regfile_if #(.DATA_W(8), .ADDR_W(4)) bus();

   bus_6502_regfile #(.DATA_W(8), .ADDR_W(4), .SYNC_STAGES(2), .LED_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [16];
   int         cnt;
   bit         nd;
   logic [3:0] wq[$];
   logic [7:0] rq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] status_val();
      logic [6:0] c;
      c = 7'(cnt % 128);
      return {c, nd};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      cnt = 0;
      nd  = 1'b0;
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic check_reset_outputs();
      @(negedge clk);
      chk("rst_data_out",  bus.data_out, 0);
      chk("rst_data_oe",   bus.data_oe, 0);
      chk("rst_irq_n",     bus.irq_n, 1);
      chk("rst_wr_strobe", bus.wr_strobe, 0);
      chk("rst_wr_addr",   bus.wr_addr, 0);
      chk("rst_led",       bus.led, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clks(3);
      check_reset_outputs();
      rst_n = 1'b1;
      model_reset();
      clks(5);
   endtask

   // One phi2 cycle; abort raises cs before the falling edge (writes only)
   task automatic bus_cycle(input bit wr, input logic [3:0] a, input logic [7:0] d, input bit abort);
      bus.rs = a; bus.wren = !wr; bus.data_in = d; bus.cs = 1'b0;
      clks(5);
      if (wr && !abort) begin
         if (a != 4'hF) begin
            mem[a] = d; cnt++; nd = 1'b1; wq.push_back(a);
         end
      end else if (!wr) begin
         rq.push_back(a == 4'hF ? status_val() : mem[a]);
         if (a == 4'hF) nd = 1'b0;
      end
      bus.clk_ext1 = 1'b1;
      clks(10);
      if (!wr) begin
         @(negedge clk);
         chk("data_oe_high", bus.data_oe, 1);
      end
      clks(5);
      if (abort) bus.cs = 1'b1;
      clks(5);
      bus.clk_ext1 = 1'b0;
      clks(6);
      bus.cs = 1'b1; bus.wren = 1'b1;
      clks(10);
      @(negedge clk);
      chk("irq_n", bus.irq_n, !nd);
      chk("led", bus.led, mem[0]);
   endtask

   // Monitor: pops expectations whenever the DUT presents a strobe or ends a read
   bit         prev_oe = 1'b0, prev_stb = 1'b0;
   logic [7:0] last_rd = 8'h00;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_oe = 1'b0; prev_stb = 1'b0;
      end else begin
         if (bus.wr_strobe) begin
            chk("strobe_width", prev_stb, 0);
            if (wq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_strobe: wr_addr %0h, no write expected", bus.wr_addr);
            end else begin
               chk("wr_addr", bus.wr_addr, wq.pop_front());
            end
         end
         if (bus.data_oe) last_rd = bus.data_out;
         if (prev_oe && !bus.data_oe) begin
            if (rq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read: data_out %0h, no read expected", last_rd);
            end else begin
               chk("rd_data", last_rd, rq.pop_front());
            end
         end
         prev_oe  = bus.data_oe;
         prev_stb = bus.wr_strobe;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: timeout reached, simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.clk_ext1 = 1'b0; bus.cs = 1'b1; bus.wren = 1'b1;
      bus.rs = '0; bus.data_in = '0;
      model_reset();
      clks(2);
      do_reset();

      // mid-access reset: no partial write survives
      bus_cycle(1, 4'h3, 8'h11, 0);
      bus.rs = 4'h3; bus.wren = 1'b0; bus.data_in = 8'h77; bus.cs = 1'b0;
      clks(5);
      bus.clk_ext1 = 1'b1;
      clks(8);
      rst_n = 1'b0;
      clks(3);
      check_reset_outputs();
      bus.clk_ext1 = 1'b0; bus.cs = 1'b1; bus.wren = 1'b1;
      clks(4);
      rst_n = 1'b1;
      model_reset();
      clks(5);
      bus_cycle(0, 4'h3, 8'h00, 0);

      // directed writes/reads
      bus_cycle(1, 4'h0, 8'hA5, 0);
      bus_cycle(1, 4'h5, 8'h3C, 0);
      bus_cycle(0, 4'h5, 8'h00, 0);

      // status: 3 writes -> 0x07, then 0x06
      do_reset();
      bus_cycle(1, 4'h1, 8'h10, 0);
      bus_cycle(1, 4'h2, 8'h20, 0);
      bus_cycle(1, 4'h4, 8'h40, 0);
      chk("status_expect_07", status_val(), 8'h07);
      bus_cycle(0, 4'hF, 8'h00, 0);
      bus_cycle(0, 4'hF, 8'h00, 0);

      // aborted write leaves reg and count untouched
      bus_cycle(1, 4'h2, 8'h55, 1);
      bus_cycle(0, 4'h2, 8'h00, 0);
      bus_cycle(0, 4'hF, 8'h00, 0);

      // randomised traffic
      for (int i = 0; i < 60; i++) begin
         bit         wr, ab;
         logic [3:0] a;
         logic [7:0] d;
         wr = 1'($urandom_range(0, 1));
         a  = 4'($urandom_range(0, 15));
         d  = 8'($urandom);
         ab = wr && ($urandom_range(0, 7) == 0);
         bus_cycle(wr, a, d, ab);
      end

      // count wrap after 129 writes; status write dropped
      do_reset();
      for (int i = 0; i < 129; i++) begin
         bus_cycle(1, 4'($urandom_range(0, 14)), 8'($urandom), 0);
      end
      chk("status_expect_03", status_val(), 8'h03);
      bus_cycle(0, 4'hF, 8'h00, 0);
      bus_cycle(1, 4'hF, 8'hFF, 0);
      bus_cycle(0, 4'hF, 8'h00, 0);

      clks(20);
      chk("wq_empty", wq.size(), 0);
      chk("rq_empty", rq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
